// File: rtl/serial_addsub_n.sv
// -----------------------------------------------------------------------------
// serial_addsub_n
//
// Bit-serial adder/subtractor. Two WIDTH-bit operands are loaded in parallel
// on a start strobe, then added (or subtracted) one bit per clock, LSB first,
// through a single full-adder slice and a carry flip-flop. Latency from the
// start edge to the done pulse is WIDTH cycles.
//
// Subtraction is A + ~B + 1: B is inverted at load time and the carry
// flip-flop is preset to 1, so the same slice serves both operations.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous reset, active-low
//   start      request; accepted only in IDLE or DONE
//   mode       0 = A+B, 1 = A-B; sampled with start
//   a, b       operands; sampled with start
//   busy       high while bits are being processed
//   done       one-cycle pulse; result/flags valid
//   result     final sum/difference, held until the next completion
//   carry_out  final carry; for subtract, 1 = no borrow
//   overflow   signed two's-complement overflow
//   sum_bit    registered serial sum bit
//   bit_valid  high for each cycle sum_bit carries a new bit
// -----------------------------------------------------------------------------
module serial_addsub_n #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             sum_bit,
    output logic             bit_valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   shreg_a_q,   shreg_a_d;
    logic [WIDTH-1:0]   shreg_b_q,   shreg_b_d;
    logic               carry_q,     carry_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   result_q,    result_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q,  overflow_d;
    logic               sum_bit_q,   sum_bit_d;
    logic               bit_valid_q, bit_valid_d;

    // The single full-adder slice working on the current LSBs.
    logic fa_s;
    logic fa_c;

    assign fa_s = shreg_a_q[0] ^ shreg_b_q[0] ^ carry_q;
    assign fa_c = (shreg_a_q[0] & shreg_b_q[0]) |
                  (shreg_a_q[0] & carry_q)      |
                  (shreg_b_q[0] & carry_q);

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        shreg_a_d   = shreg_a_q;
        shreg_b_d   = shreg_b_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        sum_bit_d   = sum_bit_q;
        bit_valid_d = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                done = (state_q == ST_DONE);
                if (start) begin
                    shreg_a_d = a;
                    shreg_b_d = mode ? ~b : b;
                    carry_d   = mode;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                busy        = 1'b1;
                sum_bit_d   = fa_s;
                bit_valid_d = 1'b1;
                carry_d     = fa_c;
                // The vacated MSB of shreg_a collects the sum bits, so after
                // WIDTH shifts it holds the complete result.
                shreg_a_d   = {fa_s, shreg_a_q[WIDTH-1:1]};
                shreg_b_d   = {1'b0, shreg_b_q[WIDTH-1:1]};
                cnt_d       = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    result_d    = {fa_s, shreg_a_q[WIDTH-1:1]};
                    carry_out_d = fa_c;
                    // Carry into the MSB differs from carry out of the MSB.
                    overflow_d  = carry_q ^ fa_c;
                    state_d     = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: the operand shift registers, carry and counter are reset too, so
    // no stale operand bits survive a mid-operation reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shreg_a_q   <= '0;
            shreg_b_q   <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            sum_bit_q   <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            shreg_a_q   <= shreg_a_d;
            shreg_b_q   <= shreg_b_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            sum_bit_q   <= sum_bit_d;
            bit_valid_q <= bit_valid_d;
        end
    end

    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign sum_bit   = sum_bit_q;
    assign bit_valid = bit_valid_q;

endmodule

// File: tb/tb_serial_addsub_n.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub_n
//
// Drives three instances (WIDTH = 8, 2, 32) with directed vectors. A cycle
// timeline model computes the expected outputs with plain integer arithmetic
// and a single compare process checks every output of every instance on each
// falling clock edge. Literal table values pin the model at each done.
// -----------------------------------------------------------------------------
module tb_serial_addsub_n;

    localparam int NU = 3;

    typedef struct packed {
        logic [63:0] res;
        logic        co;
        logic        ov;
    } op_t;

    typedef struct {
        int          u;
        logic [31:0] a;
        logic [31:0] b;
        logic        mode;
        logic [31:0] res;
        logic        co;
        logic        ov;
    } tcase_t;

    int wid [NU] = '{8, 2, 32};
    int lo  [NU] = '{0, 6, 11};
    int hi  [NU] = '{5, 10, 15};

    tcase_t tc [16];

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [NU-1:0] start_v;
    logic [NU-1:0] mode_v;
    logic [31:0]   a_v [NU];
    logic [31:0]   b_v [NU];
    int            cur_id [NU];

    logic [NU-1:0] busy_v, done_v, co_v, ov_v, sb_v, bv_v;
    logic [7:0]    res8;
    logic [1:0]    res2;
    logic [31:0]   res32;
    logic [63:0]   res_v [NU];

    always_comb begin
        res_v[0] = 64'(res8);
        res_v[1] = 64'(res2);
        res_v[2] = 64'(res32);
    end

    always #5 clk = ~clk;

    serial_addsub_n #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode_v[0]),
        .a(a_v[0][7:0]), .b(b_v[0][7:0]), .busy(busy_v[0]), .done(done_v[0]),
        .result(res8), .carry_out(co_v[0]), .overflow(ov_v[0]),
        .sum_bit(sb_v[0]), .bit_valid(bv_v[0])
    );

    serial_addsub_n #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode_v[1]),
        .a(a_v[1][1:0]), .b(b_v[1][1:0]), .busy(busy_v[1]), .done(done_v[1]),
        .result(res2), .carry_out(co_v[1]), .overflow(ov_v[1]),
        .sum_bit(sb_v[1]), .bit_valid(bv_v[1])
    );

    serial_addsub_n #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode_v[2]),
        .a(a_v[2]), .b(b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .result(res32), .carry_out(co_v[2]), .overflow(ov_v[2]),
        .sum_bit(sb_v[2]), .bit_valid(bv_v[2])
    );

    // -------------------------------------------------------------------------
    // Arithmetic reference: unsigned and signed integer math on w-bit values
    // -------------------------------------------------------------------------
    function automatic op_t model_op(input logic [31:0] a, input logic [31:0] b,
                                     input logic mode, input int w);
        longint m;
        longint ua, ub, sa, sb, r, sr;
        op_t    o;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (mode) begin
            r    = ua - ub;
            o.co = (ua >= ub);
            sr   = sa - sb;
        end else begin
            r    = ua + ub;
            o.co = (r >= m);
            sr   = sa + sb;
        end
        o.res = 64'(r & (m - 1));
        o.ov  = (sr >= m / 2) || (sr < -(m / 2));
        return o;
    endfunction

    // -------------------------------------------------------------------------
    // Timeline model: k counts cycles since the accepted start edge
    // -------------------------------------------------------------------------
    bit          act_m   [NU];
    int          k_m     [NU];
    op_t         pend    [NU];
    int          pend_id [NU];
    logic [63:0] e_res   [NU];
    logic        e_co    [NU];
    logic        e_ov    [NU];
    logic        e_sb    [NU];

    always @(posedge clk or negedge rst) begin
        for (int u = 0; u < NU; u++) begin
            if (!rst) begin
                act_m[u]   <= 1'b0;
                k_m[u]     <= 0;
                pend_id[u] <= -1;
                e_res[u]   <= '0;
                e_co[u]    <= 1'b0;
                e_ov[u]    <= 1'b0;
                e_sb[u]    <= 1'b0;
            end else if (act_m[u] && k_m[u] < wid[u]) begin
                e_sb[u] <= pend[u].res[k_m[u]];
                k_m[u]  <= k_m[u] + 1;
                if (k_m[u] == wid[u] - 1) begin
                    e_res[u] <= pend[u].res;
                    e_co[u]  <= pend[u].co;
                    e_ov[u]  <= pend[u].ov;
                end
            end else if (start_v[u]) begin
                pend[u]    <= model_op(a_v[u], b_v[u], mode_v[u], wid[u]);
                pend_id[u] <= cur_id[u];
                act_m[u]   <= 1'b1;
                k_m[u]     <= 0;
            end else begin
                act_m[u] <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Compare process
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] seq_3c25 = 8'b0110_0001;

    task automatic check(input string name, input int u,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s W=%0d t=%0t got=%0h expected=%0h",
                     name, wid[u], $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < NU; u++) begin
            logic exp_busy, exp_done, exp_bv;
            exp_busy = act_m[u] && (k_m[u] < wid[u]);
            exp_done = act_m[u] && (k_m[u] == wid[u]);
            exp_bv   = act_m[u] && (k_m[u] >= 1);
            check("busy",      u, 64'(busy_v[u]), 64'(exp_busy));
            check("done",      u, 64'(done_v[u]), 64'(exp_done));
            check("bit_valid", u, 64'(bv_v[u]),   64'(exp_bv));
            check("sum_bit",   u, 64'(sb_v[u]),   64'(e_sb[u]));
            check("result",    u, res_v[u],       e_res[u]);
            check("carry_out", u, 64'(co_v[u]),   64'(e_co[u]));
            check("overflow",  u, 64'(ov_v[u]),   64'(e_ov[u]));
            if (exp_done && pend_id[u] >= 0) begin
                check("pin_result", u, e_res[u], 64'(tc[pend_id[u]].res));
                check("pin_carry",  u, 64'(e_co[u]), 64'(tc[pend_id[u]].co));
                check("pin_ovf",    u, 64'(e_ov[u]), 64'(tc[pend_id[u]].ov));
            end
            if (u == 0 && pend_id[0] == 0 && exp_bv)
                check("pin_seq", u, 64'(e_sb[0]), 64'(seq_3c25[k_m[0] - 1]));
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    task automatic issue(input int id);
        int u;
        u = tc[id].u;
        @(negedge clk);
        start_v[u] = 1'b1;
        a_v[u]     = tc[id].a;
        b_v[u]     = tc[id].b;
        mode_v[u]  = tc[id].mode;
        cur_id[u]  = id;
        @(negedge clk);
        start_v[u] = 1'b0;
    endtask

    task automatic run_op(input int id);
        issue(id);
        repeat (wid[tc[id].u] + 1) @(negedge clk);
    endtask

    // start held high with other operands for the whole SHIFT phase
    task automatic held_start(input int id);
        int u;
        u = tc[id].u;
        issue(id);
        start_v[u] = 1'b1;
        a_v[u]     = ~tc[id].a;
        b_v[u]     = tc[id].a;
        mode_v[u]  = ~tc[id].mode;
        cur_id[u]  = -1;
        repeat (wid[u]) @(negedge clk);
        start_v[u] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // second request raised in the DONE cycle of the first
    task automatic back_to_back(input int id1, input int id2);
        int u;
        u = tc[id1].u;
        issue(id1);
        repeat (wid[u] - 1) @(negedge clk);
        run_op(id2);
    endtask

    task automatic reset_mid(input int id, input int nbits);
        issue(id);
        repeat (nbits) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        tc[0]  = '{0, 32'h3C,       32'h25,       1'b0, 32'h61,       1'b0, 1'b0};
        tc[1]  = '{0, 32'hFF,       32'h01,       1'b0, 32'h00,       1'b1, 1'b0};
        tc[2]  = '{0, 32'h7F,       32'h01,       1'b0, 32'h80,       1'b0, 1'b1};
        tc[3]  = '{0, 32'h05,       32'h07,       1'b1, 32'hFE,       1'b0, 1'b0};
        tc[4]  = '{0, 32'h80,       32'h01,       1'b1, 32'h7F,       1'b1, 1'b1};
        tc[5]  = '{0, 32'h10,       32'h10,       1'b0, 32'h20,       1'b0, 1'b0};
        tc[6]  = '{1, 32'h3,        32'h1,        1'b0, 32'h0,        1'b1, 1'b0};
        tc[7]  = '{1, 32'h1,        32'h1,        1'b0, 32'h2,        1'b0, 1'b1};
        tc[8]  = '{1, 32'h1,        32'h3,        1'b1, 32'h2,        1'b0, 1'b1};
        tc[9]  = '{1, 32'h2,        32'h1,        1'b1, 32'h1,        1'b1, 1'b1};
        tc[10] = '{1, 32'h1,        32'h0,        1'b0, 32'h1,        1'b0, 1'b0};
        tc[11] = '{2, 32'hFFFFFFFF, 32'h1,        1'b0, 32'h0,        1'b1, 1'b0};
        tc[12] = '{2, 32'h7FFFFFFF, 32'h1,        1'b0, 32'h80000000, 1'b0, 1'b1};
        tc[13] = '{2, 32'h5,        32'h7,        1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        tc[14] = '{2, 32'h80000000, 32'h1,        1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        tc[15] = '{2, 32'h10,       32'h10,       1'b0, 32'h20,       1'b0, 1'b0};

        start_v = '0;
        mode_v  = '0;
        for (int u = 0; u < NU; u++) begin
            a_v[u]    = '0;
            b_v[u]    = '0;
            cur_id[u] = -1;
        end

        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int u = 0; u < NU; u++) begin
            for (int id = lo[u]; id <= hi[u]; id++) run_op(id);
            held_start(lo[u]);
            back_to_back(lo[u] + 1, lo[u] + 2);
            reset_mid(lo[u] + 3, (wid[u] > 4) ? 4 : wid[u] - 1);
            run_op(hi[u]);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
